// File: rtl/hdmi_fb_scheduler.sv
// hdmi_fb_scheduler
//   Feeds pixels to the HDMI serialiser from a prefetch FIFO and shares one
//   single-port framebuffer RAM between the video prefetch path and a writer.
//   Everything runs in the pixel clock domain.
//
// Ports
//   i_pixclk                  pixel clock
//   i_reset_n                 synchronous active-low reset
//   i_rd                      serialiser consumes the head pixel this cycle
//   i_newframe                last pixel of frame; flushes the prefetch path
//   o_red/o_grn/o_blu         FIFO head pixel, or UNDERFLOW_RGB when empty
//   i_wr_req/i_wr_addr/i_wr_data  writer request, held until o_wr_ack
//   o_wr_ack                  one-cycle pulse, write issued this cycle
//   o_mem_addr/o_mem_re/o_mem_we/o_mem_wdata  registered RAM command
//   i_mem_rdata               RAM read data, valid the cycle after o_mem_re
//   o_level                   FIFO occupancy
//   o_underflow               sticky: i_rd seen with the FIFO empty
module hdmi_fb_scheduler #(
  parameter int          ADDR_W        = 19,
  parameter int          FB_PIXELS     = 307200,
  parameter int          FIFO_DEPTH    = 16,
  parameter int          LOW_WATER     = 4,
  parameter logic [23:0] UNDERFLOW_RGB = 24'h000000
) (
  input  logic                          i_pixclk,
  input  logic                          i_reset_n,
  input  logic                          i_rd,
  input  logic                          i_newframe,
  output logic [7:0]                    o_red,
  output logic [7:0]                    o_grn,
  output logic [7:0]                    o_blu,
  input  logic                          i_wr_req,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [23:0]                   i_wr_data,
  output logic                          o_wr_ack,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic                          o_mem_re,
  output logic                          o_mem_we,
  output logic [23:0]                   o_mem_wdata,
  input  logic [23:0]                   i_mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underflow
);

  localparam int LVL_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] ST_FLUSH = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        r_state;
  logic [23:0]       r_fifo [FIFO_DEPTH];
  logic [LVL_W-1:0]  r_wptr;
  logic [LVL_W-1:0]  r_rptr;
  logic [LVL_W:0]    r_level;
  logic [ADDR_W-1:0] r_fetch;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [23:0]       r_mem_wdata;
  logic              r_mem_re;
  logic              r_mem_we;
  logic              r_wr_ack;
  logic              r_rd_pend;   // read data on i_mem_rdata this cycle
  logic              r_drop;      // that data belongs to a flushed frame
  logic              r_underflow;

  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_rd_ok;
  logic              w_avail;
  logic              w_low;
  logic              w_wr_ok;
  logic              w_issue_rd;
  logic              w_issue_wr;
  logic [LVL_W+1:0]  w_occ;

  always_comb begin
    w_empty = (r_level == '0);
    // A new frame flushes the FIFO, so it suppresses both pop and push.
    w_pop   = i_rd && !w_empty && !i_newframe;
    w_push  = r_rd_pend && !r_drop && !i_newframe;
    // Occupancy counts every read not yet in the FIFO: the one issued this
    // cycle and the one whose data is returning now. That keeps the FIFO
    // from overflowing even when reads run back-to-back.
    w_occ   = (LVL_W+2)'(r_level) + (LVL_W+2)'(r_mem_re) + (LVL_W+2)'(r_rd_pend);
    w_avail = (w_occ < (LVL_W+2)'(FIFO_DEPTH));
    w_low   = (r_level < (LVL_W+1)'(LOW_WATER));
    w_rd_ok = (r_state == ST_RUN) && !i_newframe;
    // A request acked this cycle is still held; never grant it twice.
    w_wr_ok = i_wr_req && !r_wr_ack;
    w_issue_rd = w_rd_ok && w_avail && (w_low || !w_wr_ok);
    w_issue_wr = w_wr_ok && !(w_rd_ok && w_avail && w_low);
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      r_state     <= ST_FLUSH;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_fetch     <= '0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_drop      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state   <= i_newframe ? ST_FLUSH : ST_RUN;
      r_rd_pend <= r_mem_re;
      r_drop    <= i_newframe && r_mem_re;
      if (i_newframe) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
        r_fetch <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + LVL_W'(1);
        if (w_pop)  r_rptr <= r_rptr + LVL_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + (LVL_W+1)'(1);
          2'b01:   r_level <= r_level - (LVL_W+1)'(1);
          default: r_level <= r_level;
        endcase
        if (w_issue_rd)
          r_fetch <= (r_fetch == ADDR_W'(FB_PIXELS-1)) ? '0 : r_fetch + ADDR_W'(1);
      end
      if (i_rd && w_empty && !i_newframe) r_underflow <= 1'b1;
      r_mem_re <= w_issue_rd;
      r_mem_we <= w_issue_wr;
      r_wr_ack <= w_issue_wr;
      if (w_issue_rd)      r_mem_addr <= r_fetch;
      else if (w_issue_wr) r_mem_addr <= i_wr_addr;
    end
  end

  // Storage only; validity is tracked by the control registers above.
  always_ff @(posedge i_pixclk) begin
    if (w_push)     r_fifo[r_wptr] <= i_mem_rdata;
    if (w_issue_wr) r_mem_wdata    <= i_wr_data;
  end

  assign {o_red, o_grn, o_blu} = w_empty ? UNDERFLOW_RGB : r_fifo[r_rptr];
  assign o_wr_ack    = r_wr_ack;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_re    = r_mem_re;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_mem_wdata;
  assign o_level     = r_level;
  assign o_underflow = r_underflow;

endmodule
